rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single architectural register-file write port among NREQ writeback/commit sources (ALU, MUL/DIV, FPU, LSU).
//  Arbitration is priority plus round-robin, with starvation protection. The granted write is registered and drives the RF write port.
//  The RF captures the write on the following negedge.
//  Sits between the OoO commit/writeback stage and the 32x32 integer register file.
// PARAMETERS
//  NREQ          4        number of requesters (2..8)
//  XLEN          32       data width
//  AW            5        register address width
//  HIPRI_MASK    4'b0001  bit i=1: requester i is high priority (LSU by default)
//  STARVE_LIMIT  8        wait cycles before a low-priority requester is forced through (>=1)
// PORTS
//  clk         in   1          posedge clock
//  rst         in   1          asynchronous, active-low reset
//  req_valid   in   NREQ       write request per source; held until accepted
//  req_addr    in   NREQ*AW    dest reg, packed, source i at [i*AW +: AW]
//  req_data    in   NREQ*XLEN  write data, packed likewise
//  req_ready   out  NREQ       one-hot grant; transfer = valid & ready
//  flush       in   1          pipeline squash: no grants this cycle, starvation counters cleared
//  stall       in   1          RF port unavailable: no grants, counters frozen
//  rf_we       out  1          RF write enable
//  rf_wa       out  AW         RF write address
//  rf_wd       out  XLEN       RF write data
//  busy        out  1          |req_valid | rf_we
// BEHAVIOUR
//  - Reset (rst=0): rf_we=0, rf_wa=0, rf_wd=0, rr_ptr=0, all wait_cnt=0, perf counters=0. req_ready forced 0 while rst=0.
//    Reset mid-operation drops the pending and registered write.
//  - req_ready is combinational, at most one-hot, and 0 when stall|flush. Requesters must not drop valid or change addr/data before ready.
//  - Grant order (stall=flush=0):
//    1) Any low-prio requester with wait_cnt==STARVE_LIMIT: the lowest such index wins.
//    2) Else any valid HIPRI requester: round-robin from rr_ptr among those requesters.
//    3) Else round-robin from rr_ptr among all valid requesters.
//  - rr_ptr <= (winner+1) mod NREQ on every grant and wraps at NREQ-1 -> 0. rr_ptr is unchanged when there is no grant.
//  - wait_cnt[i] (low-prio only):
//    - +1 (saturating at STARVE_LIMIT) when valid & !ready & !stall.
//    - Cleared on grant, on !valid, or on flush.
//    - Frozen during stall.
//  - Output register (posedge), latency 1:
//    - rf_we <= grant & (addr!=0); rf_wa/rf_wd <= granted addr/data.
//    - With no grant: rf_we <= 0; rf_wa/rf_wd hold.
//  - x0 writes are accepted (ready=1) but never produce rf_we=1.
//  - A write already registered when flush/stall asserts still completes: the RF captures it at that cycle's negedge.
//  - Two requesters writing the same reg in consecutive grants: the later grant overwrites. No merging or ordering beyond grant order.
// CONFIGURATION
//  RF_WB_ARB_PERF_EN defined:
//   - Adds perf_conflict_cnt (out, 32): cycles with >=2 valid and no stall/flush.
//   - Adds perf_starve_cnt (out, 32): forced grants.
//   - Both counters wrap at 2^32 and reset to 0.
//  RF_WB_ARB_PERF_EN undefined: these ports and counters are absent. Arbitration is identical.
// STRUCTURE
//  - Shared package rf_arb_pkg: XLEN, AW, NREQ_MAX constants, req_idx_t typedef, onehot2idx function.
//  - Sub-module rr_pick: combinational round-robin picker (mask, ptr -> one-hot, idx, any).
//    Instantiated twice (hipri mask, full mask).
//  - Top level holds rr_ptr, wait_cnt array, output register, and perf counters.
// TESTING
//  1 Reset: rst=0 with all valids high -> req_ready=0, rf_we=0, rf_wa=0, rf_wd=0. After release, the first grant goes to req0.
//  2 Single write: req1 valid, addr=5, data=32'hDEADBEEF -> req_ready=4'b0010 same cycle.
//    Next cycle rf_we=1, rf_wa=5, rf_wd=DEADBEEF, and the RF holds it after the negedge.
//  3 Round-robin wrap: HIPRI_MASK=0, all 4 valid continuously -> grants 0,1,2,3,0,1. rr_ptr wraps with no duplicate grants.
//  4 x0 write: req2 valid, addr=0 -> req_ready[2]=1 and rf_we stays 0 the next cycle.
//  5 Starvation: HIPRI_MASK=4'b0001, STARVE_LIMIT=4, req0 and req2 valid continuously -> req0 granted 4 cycles.
//    req2 is granted on cycle 5. perf_starve_cnt=1 when RF_WB_ARB_PERF_EN is defined.
//  6 Stall/flush:
//    - stall=1 for 3 cycles with req3 valid -> ready=0 and rf_we=0. wait_cnt is unchanged.
//    - flush pulse with a write registered -> that write completes, and no grant occurs in the flush cycle.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package rf_arb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NREQ_MAX = 8;

    typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

    // Input must be one-hot or zero; OR-ing indices keeps this a flat mux.
    function automatic req_idx_t onehot2idx(input logic [NREQ_MAX-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] mask,
    input  req_idx_t     ptr,
    output logic [N-1:0] onehot,
    output req_idx_t     idx,
    output logic         any
);

    logic [N-1:0] upper;
    logic [N-1:0] pool;

    // Search positions >= ptr first; fall back to the whole mask to wrap around.
    always_comb begin
        upper = '0;
        for (int unsigned j = 0; j < N; j++) begin
            upper[j] = mask[j] && (req_idx_t'(j) >= ptr);
        end
        pool   = (|upper) ? upper : mask;
        onehot = '0;
        idx    = '0;
        any    = |mask;
        for (int unsigned j = 0; j < N; j++) begin
            if (pool[j] && (onehot == '0)) begin
                onehot[j] = 1'b1;
                idx       = req_idx_t'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: starvation override, then high-priority RR, then RR.
// Optional perf counters enabled by defining RF_WB_ARB_PERF_EN.
module rf_wb_arbiter
    import rf_arb_pkg::req_idx_t, rf_arb_pkg::onehot2idx, rf_arb_pkg::NREQ_MAX;
#(
    parameter int unsigned     NREQ         = 4,
    parameter int unsigned     XLEN         = rf_arb_pkg::XLEN,
    parameter int unsigned     AW           = rf_arb_pkg::AW,
    parameter logic [NREQ-1:0] HIPRI_MASK   = NREQ'(1),
    parameter int unsigned     STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    input  logic                 stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 busy
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_conflict_cnt,
    output logic [31:0]          perf_starve_cnt
`endif
);

    localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    req_idx_t        rr_ptr;
    logic [CW-1:0]   wait_cnt [NREQ];
    logic            go;
    logic [NREQ-1:0] starve, starve_oh, hi_oh, all_oh, grant;
    req_idx_t        starve_idx, hi_idx, all_idx, win_idx;
    logic            starve_any, hi_any, all_any, grant_any;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    assign go = rst & ~stall & ~flush;

    always_comb begin
        starve    = '0;
        starve_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            starve[i] = ~HIPRI_MASK[i] & req_valid[i] & (wait_cnt[i] == LIMIT);
            if (starve[i] && (starve_oh == '0)) begin
                starve_oh[i] = 1'b1;
            end
        end
    end

    assign starve_any = |starve;
    assign starve_idx = onehot2idx(NREQ_MAX'(starve_oh));

    rr_pick #(.N(NREQ)) u_pick_hi (
        .mask   (req_valid & HIPRI_MASK),
        .ptr    (rr_ptr),
        .onehot (hi_oh),
        .idx    (hi_idx),
        .any    (hi_any)
    );

    rr_pick #(.N(NREQ)) u_pick_all (
        .mask   (req_valid),
        .ptr    (rr_ptr),
        .onehot (all_oh),
        .idx    (all_idx),
        .any    (all_any)
    );

    always_comb begin
        grant   = '0;
        win_idx = '0;
        if (go) begin
            if (starve_any) begin
                grant   = starve_oh;
                win_idx = starve_idx;
            end else if (hi_any) begin
                grant   = hi_oh;
                win_idx = hi_idx;
            end else if (all_any) begin
                grant   = all_oh;
                win_idx = all_idx;
            end
        end
    end

    assign grant_any = |grant;
    assign req_ready = grant;
    assign busy      = (|req_valid) | rf_we;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes still consume a grant but never raise the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else begin
            rf_we <= grant_any & (win_addr != '0);
            if (grant_any) begin
                rr_ptr <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                rf_wa  <= win_addr;
                rf_wd  <= win_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (HIPRI_MASK[i] || flush) begin
                    wait_cnt[i] <= '0;
                end else if (!stall) begin
                    if (!req_valid[i] || grant[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (wait_cnt[i] != LIMIT) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef RF_WB_ARB_PERF_EN
    logic multi_valid;
    assign multi_valid = (req_valid & (req_valid - 1'b1)) != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_cnt <= '0;
            perf_starve_cnt   <= '0;
        end else begin
            if (multi_valid && !stall && !flush) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (grant_any && starve_any) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
